page_ref_unit: RTL and testbench
================================

Name: page_ref_unit

Overview:
- Downstream consumer of the 8-bit page-reference FIFO.
- Pops one page number whenever the FIFO is non-empty and the unit is enabled.
- Looks the page up in a small fully-associative frame table and, on a miss, places it using FIFO (oldest-first) replacement.
- Produces per-reference hit/miss/eviction pulses and saturating statistics counters for the LASD page-replacement exercise.

Parameters:
- DATA_W, 8: width of a page number (matches FIFO data width).
- FRAMES, 4: number of physical frames; must be a power of two, at least 2.
- CNT_W, 8: width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  enable; when low, no new pops start. An in-flight reference still completes.
- clr  in  1  synchronous clear of counters, frame table and victim pointer; has priority over all other activity.
- fifo_empty  in  1  Empty flag from upstream FIFO.
- fifo_rd  out  1  read strobe to FIFO; one-cycle pulse.
- fifo_data  in  DATA_W  FIFO DataOut; valid the cycle after fifo_rd.
- busy  out  1  high while a reference is in flight (states RD_WAIT, LOOKUP).
- hit  out  1  one-cycle pulse: page resident.
- miss  out  1  one-cycle pulse: page not resident (cold or evicting).
- evict  out  1  one-cycle pulse: miss that replaced a valid frame (page fault).
- evicted_page  out  DATA_W  page displaced on the evict cycle; holds its value otherwise.
- hit_cnt  out  CNT_W  total hits, saturating.
- miss_cnt  out  CNT_W  total misses, saturating.
- fault_cnt  out  CNT_W  total evictions, saturating.

Behaviour:
- Reset (rst=0, async): state=IDLE; all frame valid bits 0; victim_ptr=0. All outputs are 0: fifo_rd, busy, hit, miss, evict, evicted_page, and the three counters.
- FSM states: IDLE, RD_WAIT, LOOKUP.
- IDLE: if en && !fifo_empty && !clr, assert fifo_rd (registered, high for exactly one cycle) and go to RD_WAIT.
- RD_WAIT: FIFO presents data; fifo_data is sampled at the end of this cycle into page_q. Go to LOOKUP.
- LOOKUP: compare page_q against all valid frames in one cycle, then return to IDLE.
  - Hit: hit=1; hit_cnt+1.
  - Miss with frame[victim_ptr] invalid (cold): miss=1; write page_q into frame[victim_ptr], set its valid bit; miss_cnt+1.
  - Miss with frame[victim_ptr] valid (fault): miss=1, evict=1; evicted_page=old frame[victim_ptr]; overwrite that frame; miss_cnt+1, fault_cnt+1.
  - On any miss, victim_ptr increments modulo FRAMES (wraps FRAMES-1 to 0). Hits never move victim_ptr.
- Throughput: one reference per 3 cycles. Latency from fifo_rd to the hit/miss pulse is 2 cycles.
- fifo_empty is sampled only in IDLE. A FIFO that becomes empty during RD_WAIT or LOOKUP does not abort the in-flight reference.
- en falling mid-reference: the reference completes, then the FSM stays in IDLE.
- Counters saturate at 2^CNT_W-1 and never wrap. miss_cnt and fault_cnt saturate independently.
- clr=1: counters=0, valid bits=0, victim_ptr=0, state=IDLE. An in-flight reference is discarded with no pulses. If clr arrives in RD_WAIT, the popped byte is dropped.
- Duplicate pages never coexist in the table; a match sets hit before any insert is considered.
- Only the valid bits need reset; frame data contents may be left unreset.

Decomposition:
- Package page_ref_pkg:
  - state enum (IDLE, RD_WAIT, LOOKUP);
  - default constants DATA_W=8, FRAMES=4, CNT_W=8;
  - function for the saturating increment.
- One sub-module, sat_counter (parameter W; ports inc, clr, q; clk and rst active-low async), instantiated three times.

Test Plan (all with default parameters):
- Reset check: hold rst=0 with fifo_empty=0 and en=1 -> fifo_rd stays 0, all counters 0. After release, the first fifo_rd appears on the first clk edge.
- Cold fill: feed 1,2,3,4 -> 4 miss pulses, 0 evict pulses; miss_cnt=4, fault_cnt=0, hit_cnt=0; each fifo_rd pulse is spaced 3 cycles apart.
- Hit then fault: after cold fill feed 1,5,1 -> hit on 1; 5 evicts 1 (evicted_page=1); 1 then evicts 2 (evicted_page=2). Final hit_cnt=1, miss_cnt=6, fault_cnt=2.
- Flow control: fifo_empty=1 for 10 cycles, or en=0 asserted during RD_WAIT -> no new fifo_rd, and the in-flight reference still produces exactly one hit or miss pulse.
- Saturation: 300 references of the same page 7 -> hit_cnt=255 and holds there; miss_cnt=1.
- clr mid-operation: assert clr in RD_WAIT after the table holds 1..4 -> no pulse, all counters 0. Next reference 1 gives a cold miss (evict=0).

Source files
------------

// File: rtl/page_ref_pkg.sv
// Shared types and helpers for the page-reference consumer.
package page_ref_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    LOOKUP  = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_FRAMES = 4;
  localparam int DEF_CNT_W  = 8;

  // Increment v, sticking at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max;
    max = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter with synchronous clear.
module sat_counter
  import page_ref_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_q <= '0;
    else if (clr)  r_q <= '0;
    else if (inc)  r_q <= W'(sat_inc(32'(r_q), W));
  end

  assign q = r_q;

endmodule

// File: rtl/page_ref_unit.sv
// Pops page numbers from the upstream FIFO and runs them through a small
// fully-associative frame table with oldest-first replacement.
module page_ref_unit
  import page_ref_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAMES = DEF_FRAMES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              busy,
  output logic              hit,
  output logic              miss,
  output logic              evict,
  output logic [DATA_W-1:0] evicted_page,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  fault_cnt
);

  localparam int PW = $clog2(FRAMES);

  state_e              r_state, w_next;
  logic                r_fifo_rd;
  logic [DATA_W-1:0]   r_page_q;
  logic [DATA_W-1:0]   r_frame [FRAMES];
  logic [FRAMES-1:0]   r_valid;
  logic [PW-1:0]       r_vptr;
  logic                r_hit, r_miss, r_evict;
  logic [DATA_W-1:0]   r_ev_page;

  logic                w_busy, w_pop, w_lookup;
  logic [FRAMES-1:0]   w_match;
  logic                w_hit, w_vic_valid;
  logic                w_inc_hit, w_inc_miss, w_inc_fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_state <= IDLE;
    else if (clr)  r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en && !fifo_empty) w_next = RD_WAIT;
      RD_WAIT: w_next = LOOKUP;
      LOOKUP:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // clr suppresses both a new pop and the result of a lookup in progress.
  always_comb begin
    w_busy   = (r_state != IDLE);
    w_pop    = (r_state == IDLE) && en && !fifo_empty && !clr;
    w_lookup = (r_state == LOOKUP) && !clr;
  end

  always_comb begin
    for (int i = 0; i < FRAMES; i++)
      w_match[i] = r_valid[i] && (r_frame[i] == r_page_q);
  end

  assign w_hit       = |w_match;
  assign w_vic_valid = r_valid[r_vptr];
  assign w_inc_hit   = w_lookup && w_hit;
  assign w_inc_miss  = w_lookup && !w_hit;
  assign w_inc_fault = w_lookup && !w_hit && w_vic_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fifo_rd <= 1'b0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_evict   <= 1'b0;
      r_ev_page <= '0;
      r_valid   <= '0;
      r_vptr    <= '0;
    end else begin
      r_fifo_rd <= w_pop;
      r_hit     <= w_inc_hit;
      r_miss    <= w_inc_miss;
      r_evict   <= w_inc_fault;
      if (w_inc_fault) r_ev_page <= r_frame[r_vptr];
      if (clr) begin
        r_valid <= '0;
        r_vptr  <= '0;
      end else if (w_inc_miss) begin
        r_valid[r_vptr] <= 1'b1;
        r_vptr          <= r_vptr + 1'b1;
      end
    end
  end

  // Page latch and frame contents need no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (r_state == RD_WAIT) r_page_q <= fifo_data;
    if (w_inc_miss)         r_frame[r_vptr] <= r_page_q;
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk(clk), .rst(rst), .inc(w_inc_hit),   .clr(clr), .q(hit_cnt)
  );
  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk(clk), .rst(rst), .inc(w_inc_miss),  .clr(clr), .q(miss_cnt)
  );
  sat_counter #(.W(CNT_W)) u_fault_cnt (
    .clk(clk), .rst(rst), .inc(w_inc_fault), .clr(clr), .q(fault_cnt)
  );

  assign fifo_rd      = r_fifo_rd;
  assign busy         = w_busy;
  assign hit          = r_hit;
  assign miss         = r_miss;
  assign evict        = r_evict;
  assign evicted_page = r_ev_page;

endmodule

// File: tb/tb_page_ref_unit.sv
// Randomized bench for page_ref_unit against a resident-page queue model.
module tb_page_ref_unit;

  localparam int FR   = 4;
  localparam int CMAX = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'd0;
  logic       fifo_rd, busy, hit, miss, evict;
  logic [7:0] evicted_page, hit_cnt, miss_cnt, fault_cnt;

  always #5 clk = ~clk;

  page_ref_unit #(.DATA_W(8), .FRAMES(FR), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .busy(busy), .hit(hit), .miss(miss), .evict(evict),
    .evicted_page(evicted_page),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .fault_cnt(fault_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Upstream FIFO contents and the reference model: resident pages in
  // arrival order, so the front is always the next victim.
  logic [7:0] fq[$];
  logic [7:0] res[$];
  int         m_hit = 0, m_miss = 0, m_fault = 0;
  logic [7:0] m_last_ev = 8'd0;

  logic       s0 = 1'b0, s1 = 1'b0;
  logic [7:0] pg0 = 8'd0, pg1 = 8'd0;
  int         cyc = 0, last_rd_cyc = -1, n_rd = 0, n_pulse = 0, n_evict = 0;
  logic       gap_chk = 1'b0;

  task automatic model_ref(input logic [7:0] p, output logic e_hit,
                           output logic e_evict, output logic [7:0] e_ev);
    int idx;
    idx = -1;
    foreach (res[i]) if (res[i] == p) idx = i;
    e_hit   = (idx >= 0);
    e_evict = 1'b0;
    if (e_hit) begin
      if (m_hit < CMAX) m_hit++;
    end else begin
      if (m_miss < CMAX) m_miss++;
      if (res.size() == FR) begin
        e_evict   = 1'b1;
        m_last_ev = res.pop_front();
        if (m_fault < CMAX) m_fault++;
      end
      res.push_back(p);
    end
    e_ev = m_last_ev;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_hit_cnt"},   32'(hit_cnt),   32'(m_hit));
    chk({tag, "_miss_cnt"},  32'(miss_cnt),  32'(m_miss));
    chk({tag, "_fault_cnt"}, 32'(fault_cnt), 32'(m_fault));
  endtask

  // One clock: observe at the falling edge, score, then drive the next inputs.
  task automatic step();
    logic applied, pulse, eh, ee;
    logic [7:0] ev;
    applied = clr;
    @(negedge clk);
    cyc++;
    pulse = hit | miss;
    if (s0 && fq.size() != 0) void'(fq.pop_front());
    if (applied) begin
      s0 = 1'b0;
      s1 = 1'b0;
      res.delete();
      m_hit = 0; m_miss = 0; m_fault = 0;
      chk("clr_pulse", 32'(pulse), 32'd0);
      check_counts("clr");
    end else begin
      chk("pulse", 32'(pulse), 32'(s1));
      if (s1) begin
        model_ref(pg1, eh, ee, ev);
        chk("hit",      32'(hit),          32'(eh));
        chk("miss",     32'(miss),         32'(!eh));
        chk("evict",    32'(evict),        32'(ee));
        chk("ev_page",  32'(evicted_page), 32'(ev));
        check_counts("ref");
        n_pulse++;
        if (evict) n_evict++;
      end
    end
    if (fifo_rd) begin
      n_rd++;
      if (gap_chk && last_rd_cyc >= 0) chk("rd_gap", 32'(cyc - last_rd_cyc), 32'd3);
      last_rd_cyc = cyc;
    end
    s1  = s0;
    pg1 = pg0;
    s0  = fifo_rd;
    pg0 = fifo_data;
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 8'($urandom) : fq[0];
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while ((fq.size() != 0 || s0 || s1 || busy) && k < max) begin
      step();
      k++;
    end
    if (k >= max) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rd(input int max);
    int k;
    k = 0;
    while (!s0 && k < max) begin
      step();
      k++;
    end
    if (!s0) chk("rd_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int rd0, p0, e0;

    fq.push_back(8'd1); fq.push_back(8'd2); fq.push_back(8'd3); fq.push_back(8'd4);
    fifo_empty = 1'b0;
    fifo_data  = 8'd1;
    en  = 1'b1;
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("rst_rd", 32'(fifo_rd), 32'd0);
    end
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_evpage", 32'(evicted_page), 32'd0);
    check_counts("rst");

    // Cold fill: first pop on the first edge after release, then every 3 cycles.
    rst = 1'b1;
    gap_chk = 1'b1;
    step();
    chk("first_rd", 32'(fifo_rd), 32'd1);
    drain(100);
    gap_chk = 1'b0;
    chk("cold_miss_cnt", 32'(miss_cnt), 32'd4);
    chk("cold_fault_cnt", 32'(fault_cnt), 32'd0);
    chk("cold_evicts", 32'(n_evict), 32'd0);

    // Hit on 1, 5 displaces 1, then 1 displaces 2.
    fq.push_back(8'd1); fq.push_back(8'd5); fq.push_back(8'd1);
    drain(100);
    chk("hf_hit_cnt", 32'(hit_cnt), 32'd1);
    chk("hf_miss_cnt", 32'(miss_cnt), 32'd6);
    chk("hf_fault_cnt", 32'(fault_cnt), 32'd2);
    chk("hf_evpage", 32'(evicted_page), 32'd2);

    // Empty FIFO for 10 cycles: no pops.
    rd0 = n_rd;
    repeat (10) step();
    chk("empty_rd", 32'(n_rd - rd0), 32'd0);

    // en drops while a reference is in RD_WAIT: it still completes, nothing new starts.
    fq.push_back(8'd9); fq.push_back(8'd10);
    wait_rd(10);
    en  = 1'b0;
    rd0 = n_rd;
    p0  = n_pulse;
    repeat (10) step();
    chk("en_rd", 32'(n_rd - rd0), 32'd0);
    chk("en_pulse", 32'(n_pulse - p0), 32'd1);
    en = 1'b1;
    drain(100);

    // Random traffic with enable gaps and occasional clears.
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) fq.push_back(8'($urandom_range(0, 9)));
      en  = ($urandom_range(0, 4) != 0);
      clr = ($urandom_range(0, 99) == 0);
      step();
      clr = 1'b0;
    end
    en = 1'b1;
    drain(400);

    // Saturation: same page 300 times from a cleared table.
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (300) fq.push_back(8'd7);
    drain(2000);
    chk("sat_hit_cnt", 32'(hit_cnt), 32'd255);
    chk("sat_miss_cnt", 32'(miss_cnt), 32'd1);
    chk("sat_fault_cnt", 32'(fault_cnt), 32'd0);

    // clr during RD_WAIT with pages 1..4 resident: byte dropped, state wiped.
    clr = 1'b1;
    step();
    clr = 1'b0;
    fq.push_back(8'd1); fq.push_back(8'd2); fq.push_back(8'd3); fq.push_back(8'd4);
    drain(100);
    fq.push_back(8'd2);
    wait_rd(10);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("clr_miss_cnt", 32'(miss_cnt), 32'd0);
    p0 = n_pulse;
    repeat (3) step();
    chk("clr_no_pulse", 32'(n_pulse - p0), 32'd0);
    e0 = n_evict;
    fq.push_back(8'd1);
    drain(100);
    chk("post_clr_evict", 32'(n_evict - e0), 32'd0);
    chk("post_clr_miss_cnt", 32'(miss_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d, expected finish", cyc);
    $fatal(1);
  end

endmodule
